// File: rtl/mgmt_master.sv
// Management bus master: turns one core request into one slave-bus access with a 2-cycle request-low gap.
// Optional response timeout enabled by defining MGMT_TIMEOUT_EN.
module mgmt_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [31:0] cpu_adr,
  input  logic        cpu_rwn,
  input  logic [1:0]  cpu_wen,
  input  logic [31:0] cpu_txd,
  output logic        cpu_busy,
  output logic        cpu_rdy,
  output logic        cpu_err,
  output logic [31:0] cpu_rxd,
  output logic        mgmt_req,
  output logic [31:0] mgmt_adr,
  output logic        mgmt_rwn,
  output logic [1:0]  mgmt_wen,
  output logic [31:0] mgmt_txd,
  input  logic        mgmt_ack,
  input  logic        mgmt_rxe,
  input  logic [31:0] mgmt_rxd
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t      state, state_nxt;
  logic        busy_nxt, rdy_nxt, req_nxt, rwn_nxt;
  logic [31:0] rxd_nxt, adr_nxt, txd_nxt;
  logic [1:0]  wen_nxt;
  logic        timeout;

`ifdef MGMT_TIMEOUT_EN
  logic [7:0] cnt, cnt_nxt;
  logic       err_nxt;
  assign timeout = (cnt == 8'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
  assign cpu_err = 1'b0;
`endif

  // State and all outputs are registered; the comb blocks below only compute next values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cpu_busy <= 1'b0;
      cpu_rdy  <= 1'b0;
      cpu_rxd  <= '0;
      mgmt_req <= 1'b0;
      mgmt_adr <= '0;
      mgmt_rwn <= 1'b0;
      mgmt_wen <= '0;
      mgmt_txd <= '0;
`ifdef MGMT_TIMEOUT_EN
      cnt      <= '0;
      cpu_err  <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      cpu_busy <= busy_nxt;
      cpu_rdy  <= rdy_nxt;
      cpu_rxd  <= rxd_nxt;
      mgmt_req <= req_nxt;
      mgmt_adr <= adr_nxt;
      mgmt_rwn <= rwn_nxt;
      mgmt_wen <= wen_nxt;
      mgmt_txd <= txd_nxt;
`ifdef MGMT_TIMEOUT_EN
      cnt      <= cnt_nxt;
      cpu_err  <= err_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cpu_req) state_nxt = REQ;
      REQ:     if (mgmt_ack || timeout) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus fields hold from one accept to the next; ack wins over a coincident timeout.
  always_comb begin
    busy_nxt = (state_nxt != IDLE);
    rdy_nxt  = 1'b0;
    rxd_nxt  = cpu_rxd;
    req_nxt  = mgmt_req;
    adr_nxt  = mgmt_adr;
    rwn_nxt  = mgmt_rwn;
    wen_nxt  = mgmt_wen;
    txd_nxt  = mgmt_txd;
`ifdef MGMT_TIMEOUT_EN
    cnt_nxt  = cnt;
    err_nxt  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (cpu_req) begin
          req_nxt = 1'b1;
          adr_nxt = cpu_adr;
          rwn_nxt = cpu_rwn;
          wen_nxt = cpu_wen;
          txd_nxt = cpu_txd;
`ifdef MGMT_TIMEOUT_EN
          cnt_nxt = '0;
`endif
        end
      end
      REQ: begin
        if (mgmt_ack) begin
          req_nxt = 1'b0;
          rdy_nxt = 1'b1;
          rxd_nxt = mgmt_rxe ? mgmt_rxd : 32'h0;
        end else if (timeout) begin
          req_nxt = 1'b0;
          rdy_nxt = 1'b1;
          rxd_nxt = 32'h0;
`ifdef MGMT_TIMEOUT_EN
          err_nxt = 1'b1;
`endif
        end else begin
`ifdef MGMT_TIMEOUT_EN
          cnt_nxt = cnt + 8'd1;
`endif
        end
      end
      GAP:     req_nxt = 1'b0;
      default: req_nxt = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mgmt_master.sv
// Directed bench for mgmt_master: vector table of single accesses plus timeout, back-to-back and reset sequences.
module tb_mgmt_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_adr = '0;
  logic        cpu_rwn = 1'b0;
  logic [1:0]  cpu_wen = '0;
  logic [31:0] cpu_txd = '0;
  logic        cpu_busy, cpu_rdy, cpu_err;
  logic [31:0] cpu_rxd;
  logic        mgmt_req, mgmt_rwn;
  logic [31:0] mgmt_adr, mgmt_txd;
  logic [1:0]  mgmt_wen;
  logic        mgmt_ack = 1'b0;
  logic        mgmt_rxe = 1'b0;
  logic [31:0] mgmt_rxd = '0;

  int errors = 0;
  int checks = 0;

  mgmt_master #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_adr(cpu_adr), .cpu_rwn(cpu_rwn), .cpu_wen(cpu_wen), .cpu_txd(cpu_txd),
    .cpu_busy(cpu_busy), .cpu_rdy(cpu_rdy), .cpu_err(cpu_err), .cpu_rxd(cpu_rxd),
    .mgmt_req(mgmt_req), .mgmt_adr(mgmt_adr), .mgmt_rwn(mgmt_rwn), .mgmt_wen(mgmt_wen),
    .mgmt_txd(mgmt_txd), .mgmt_ack(mgmt_ack), .mgmt_rxe(mgmt_rxe), .mgmt_rxd(mgmt_rxd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rwn;
    logic [31:0] adr;
    logic [1:0]  wen;
    logic [31:0] txd;
    int          delay;
    logic        rxe;
    logic [31:0] rxd;
    logic [31:0] exp_rxd;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access: request at a negedge, ack sampled on edge 'delay' after the accept edge.
  task automatic run_txn(input vec_t v);
    @(negedge clk);
    cpu_req = 1'b1; cpu_adr = v.adr; cpu_rwn = v.rwn; cpu_wen = v.wen; cpu_txd = v.txd;
    tick();
    check("accept_req", {31'b0, mgmt_req}, 32'd1);
    check("accept_busy", {31'b0, cpu_busy}, 32'd1);
    check("accept_adr", mgmt_adr, v.adr);
    check("accept_ctl", {29'b0, mgmt_rwn, mgmt_wen}, {29'b0, v.rwn, v.wen});
    for (int k = 1; k <= v.delay; k++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      cpu_adr = ~v.adr;
      cpu_txd = ~v.txd;
      if (k == v.delay) begin
        mgmt_ack = 1'b1; mgmt_rxe = v.rxe; mgmt_rxd = v.rxd;
      end
      tick();
      check("hold_txd", mgmt_txd, v.txd);
      check("hold_adr", mgmt_adr, v.adr);
      if (k < v.delay) begin
        check("wait_rdy", {31'b0, cpu_rdy}, 32'd0);
        check("wait_req", {31'b0, mgmt_req}, 32'd1);
      end
    end
    check("done_rdy", {31'b0, cpu_rdy}, 32'd1);
    check("done_err", {31'b0, cpu_err}, 32'd0);
    check("done_rxd", cpu_rxd, v.exp_rxd);
    check("done_req", {31'b0, mgmt_req}, 32'd0);
    check("done_busy", {31'b0, cpu_busy}, 32'd1);
    @(negedge clk);
    mgmt_ack = 1'b0; mgmt_rxe = 1'b0; mgmt_rxd = '0;
    tick();
    check("gap_rdy", {31'b0, cpu_rdy}, 32'd0);
    check("gap_busy", {31'b0, cpu_busy}, 32'd0);
    check("gap_rxd_hold", cpu_rxd, v.exp_rxd);
    check("gap_txd_hold", mgmt_txd, v.txd);
  endtask

  initial begin
    int rdy_edge;
    int low_cycles;
    logic saw_err;
    logic [31:0] saw_rxd;
    logic saw_req;

    vecs[0] = '{1'b1, 32'h0000_0010, 2'b00, 32'h0,         3,  1'b1, 32'h1234_5678, 32'h1234_5678};
    vecs[1] = '{1'b0, 32'h0000_0020, 2'b01, 32'h0000_ABCD, 1,  1'b0, 32'hDEAD_BEEF, 32'h0};
    vecs[2] = '{1'b1, 32'hFFFF_FFFC, 2'b00, 32'h0,         1,  1'b1, 32'hA5A5_5A5A, 32'hA5A5_5A5A};
    vecs[3] = '{1'b0, 32'h0000_0104, 2'b11, 32'hFFFF_FFFF, 5,  1'b0, 32'h0,         32'h0};
    vecs[4] = '{1'b1, 32'h8000_0000, 2'b10, 32'h5555_0000, 2,  1'b1, 32'h8000_0001, 32'h8000_0001};
    vecs[5] = '{1'b1, 32'h0000_0040, 2'b00, 32'h0,         16, 1'b1, 32'h0BAD_F00D, 32'h0BAD_F00D};

    tick();
    tick();
    check("rst_outputs", {26'b0, cpu_busy, cpu_rdy, cpu_err, mgmt_req, mgmt_rwn, 1'b0}, 32'd0);
    check("rst_adr", mgmt_adr, 32'd0);
    check("rst_txd", mgmt_txd, 32'd0);
    check("rst_rxd", cpu_rxd, 32'd0);
    check("rst_wen", {30'b0, mgmt_wen}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Ack/rxe while idle must not complete anything.
    @(negedge clk);
    mgmt_ack = 1'b1; mgmt_rxe = 1'b1; mgmt_rxd = 32'hFFFF_0000;
    tick();
    check("idle_ack_rdy", {31'b0, cpu_rdy}, 32'd0);
    check("idle_ack_rxd", cpu_rxd, 32'd0);
    @(negedge clk);
    mgmt_ack = 1'b0; mgmt_rxe = 1'b0; mgmt_rxd = '0;

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Silent slave: timeout build completes with error, otherwise waits indefinitely.
    @(negedge clk);
    cpu_req = 1'b1; cpu_adr = 32'h0000_0080; cpu_rwn = 1'b1; cpu_wen = 2'b00; cpu_txd = '0;
    tick();
    @(negedge clk);
    cpu_req = 1'b0;
    rdy_edge = 0; saw_err = 1'b0; saw_rxd = 32'hFFFF_FFFF; saw_req = 1'b1;
`ifdef MGMT_TIMEOUT_EN
    for (int k = 1; k <= 20 && rdy_edge == 0; k++) begin
      tick();
      if (cpu_rdy) begin
        rdy_edge = k; saw_err = cpu_err; saw_rxd = cpu_rxd; saw_req = mgmt_req;
      end
    end
    check("to_edge", rdy_edge, 32'd16);
    check("to_err", {31'b0, saw_err}, 32'd1);
    check("to_rxd", saw_rxd, 32'd0);
    check("to_req", {31'b0, saw_req}, 32'd0);
    tick();
    check("to_gap_err", {31'b0, cpu_err}, 32'd0);
    check("to_gap_busy", {31'b0, cpu_busy}, 32'd0);
`else
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (cpu_rdy && rdy_edge == 0) rdy_edge = k;
    end
    check("noto_rdy", rdy_edge, 32'd0);
    check("noto_err", {31'b0, cpu_err}, 32'd0);
    check("noto_req", {31'b0, mgmt_req}, 32'd1);
    @(negedge clk);
    mgmt_ack = 1'b1; mgmt_rxe = 1'b1; mgmt_rxd = 32'hCAFE_0001;
    tick();
    check("noto_done_rdy", {31'b0, cpu_rdy}, 32'd1);
    check("noto_done_rxd", cpu_rxd, 32'hCAFE_0001);
    @(negedge clk);
    mgmt_ack = 1'b0; mgmt_rxe = 1'b0; mgmt_rxd = '0;
    tick();
`endif

    // Back-to-back: cpu_req held high, address changed while busy.
    @(negedge clk);
    cpu_req = 1'b1; cpu_adr = 32'h0000_0100; cpu_rwn = 1'b0; cpu_wen = 2'b11; cpu_txd = 32'h1111_2222;
    tick();
    @(negedge clk);
    cpu_adr = 32'h0000_0200; cpu_txd = 32'h3333_4444;
    tick();
    check("b2b_busy_adr", mgmt_adr, 32'h0000_0100);
    @(negedge clk);
    mgmt_ack = 1'b1;
    tick();
    check("b2b_rdy", {31'b0, cpu_rdy}, 32'd1);
    check("b2b_hold_adr", mgmt_adr, 32'h0000_0100);
    @(negedge clk);
    mgmt_ack = 1'b0;
    low_cycles = 1;
    for (int k = 0; k < 8 && mgmt_req == 1'b0; k++) begin
      tick();
      if (!mgmt_req) low_cycles++;
    end
    check("b2b_low_cycles", low_cycles, 32'd2);
    check("b2b_second_adr", mgmt_adr, 32'h0000_0200);
    check("b2b_second_txd", mgmt_txd, 32'h3333_4444);

    // Reset one cycle after the second accept: abort without a completion pulse.
    @(negedge clk);
    cpu_req = 1'b0;
    mgmt_ack = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("rst_mid_req", {31'b0, mgmt_req}, 32'd0);
    check("rst_mid_busy", {31'b0, cpu_busy}, 32'd0);
    check("rst_mid_adr", mgmt_adr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mgmt_ack = 1'b1; mgmt_rxe = 1'b1; mgmt_rxd = 32'h7777_7777;
    tick();
    check("rst_after_rdy", {31'b0, cpu_rdy}, 32'd0);
    check("rst_after_busy", {31'b0, cpu_busy}, 32'd0);
    check("rst_after_rxd", cpu_rxd, 32'd0);
    @(negedge clk);
    mgmt_ack = 1'b0; mgmt_rxe = 1'b0; mgmt_rxd = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
